// File: rtl/codec_adc_receiver_pkg.sv
// Shared types for the codec ADC receiver: FSM states, channel tag and sample type.
package codec_adc_receiver_pkg;
  localparam int AUDIO_WIDTH = 16;
  localparam int SYNC_DEPTH  = 2;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } rx_state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } rx_chan_t;

  typedef logic [AUDIO_WIDTH-1:0] sample_t;
endpackage

// File: rtl/codec_adc_receiver_if.sv
// I2S ADC pins; the codec is the bus master and drives all three.
interface codec_adc_receiver_if;
  logic AUD_BCLK;
  logic AUD_ADCLRCK;
  logic AUD_ADCDAT;

  modport master (output AUD_BCLK, output AUD_ADCLRCK, output AUD_ADCDAT);
  modport slave  (input  AUD_BCLK, input  AUD_ADCLRCK, input  AUD_ADCDAT);
endinterface

// File: rtl/codec_adc_receiver_sync_edge_detect.sv
// Multi-flop synchronizer with registered level and rise/fall strobes.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // level_q doubles as the previous sample, so strobes and level stay cycle-aligned
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= STAGES'({sync_q, async_i});
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/codec_adc_receiver.sv
// I2S ADC deserializer: synchronizes codec pins and assembles left/right sample pairs.
module codec_adc_receiver
  import codec_adc_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_WIDTH,
  parameter int SYNC_STAGES = SYNC_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  codec_adc_receiver_if.slave    aud,
  output logic [DATA_WIDTH-1:0]  Left_out,
  output logic [DATA_WIDTH-1:0]  Right_out,
  output logic                   Sample_valid,
  output logic                   Frame_error
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic bclk_rise_s, lrck_rise_s, lrck_fall_s, dat_s;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk (
    .clk_i(Clk), .rst_i(Reset), .async_i(aud.AUD_BCLK),
    .level_o(), .rise_o(bclk_rise_s), .fall_o()
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_lrck (
    .clk_i(Clk), .rst_i(Reset), .async_i(aud.AUD_ADCLRCK),
    .level_o(), .rise_o(lrck_rise_s), .fall_o(lrck_fall_s)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_dat (
    .clk_i(Clk), .rst_i(Reset), .async_i(aud.AUD_ADCDAT),
    .level_o(dat_s), .rise_o(), .fall_o()
  );

  rx_state_t             state_q;
  rx_chan_t              ch_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q, hold_q, left_q, right_q;
  logic                  valid_q, ferr_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [CNT_W-1:0]      cnt_d;
  logic                  lrck_edge_s;

  assign shreg_d     = {shreg_q[DATA_WIDTH-2:0], dat_s};
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign lrck_edge_s = lrck_rise_s | lrck_fall_s;

  // Frame FSM; an LRCK edge always wins over a BCLK edge seen in the same cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ALIGN;
      ch_q    <= CH_LEFT;
      cnt_q   <= '0;
      shreg_q <= '0;
      hold_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        ALIGN: begin
          if (lrck_fall_s) begin
            state_q <= SKIP;
            ch_q    <= CH_LEFT;
          end
        end
        SKIP, SHIFT: begin
          if (lrck_edge_s) begin
            ferr_q  <= 1'b1;
            hold_q  <= '0;
            state_q <= ALIGN;
          end else if (bclk_rise_s && state_q == SKIP) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else if (bclk_rise_s) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            if (cnt_d == CNT_W'(DATA_WIDTH)) begin
              if (ch_q == CH_LEFT) begin
                hold_q <= shreg_d;
              end else begin
                left_q  <= hold_q;
                right_q <= shreg_d;
                valid_q <= 1'b1;
              end
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (lrck_rise_s) begin
            state_q <= SKIP;
            ch_q    <= CH_RIGHT;
          end else if (lrck_fall_s) begin
            state_q <= SKIP;
            ch_q    <= CH_LEFT;
          end
        end
        default: state_q <= ALIGN;
      endcase
    end
  end

  assign Left_out     = left_q;
  assign Right_out    = right_q;
  assign Sample_valid = valid_q;
  assign Frame_error  = ferr_q;
endmodule

// File: tb/tb_codec_adc_receiver.sv
// Directed + random I2S frames against a scoreboard of expected left/right pairs.
module tb_codec_adc_receiver;
  import codec_adc_receiver_pkg::*;

  localparam int W  = 16;
  localparam int SS = 2;

  logic Clk = 1'b0;
  logic Reset;
  logic [W-1:0] left_s, right_s;
  logic sv_s, fe_s;

  always #5 Clk = ~Clk;

  codec_adc_receiver_if aud ();

  codec_adc_receiver #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .Clk(Clk), .Reset(Reset), .aud(aud),
    .Left_out(left_s), .Right_out(right_s),
    .Sample_valid(sv_s), .Frame_error(fe_s)
  );

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int sv_cnt = 0;
  longint cyc = 0;
  longint lsb_cyc = 0;
  longint valid_cyc = 0;
  sample_t exp_l_q[$];
  sample_t exp_r_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts strobes and pops the scoreboard on every Sample_valid
  always @(posedge Clk) begin
    cyc = cyc + 1;
    #1;
    if (fe_s === 1'b1) fe_cnt++;
    if (sv_s === 1'b1) begin
      sv_cnt++;
      valid_cyc = cyc;
      check("valid_expected", 32'(exp_l_q.size() > 0), 32'd1);
      if (exp_l_q.size() > 0) begin
        check("left_sb", 32'(left_s), 32'(exp_l_q.pop_front()));
        check("right_sb", 32'(right_s), 32'(exp_r_q.pop_front()));
      end
    end
  end

  task automatic bit_period(input logic lr, input logic d, input bit mark);
    @(negedge Clk);
    aud.AUD_BCLK    = 1'b0;
    aud.AUD_ADCLRCK = lr;
    aud.AUD_ADCDAT  = d;
    repeat (3) @(negedge Clk);
    @(negedge Clk);
    aud.AUD_BCLK = 1'b1;
    if (mark) lsb_cyc = cyc;
    repeat (3) @(negedge Clk);
  endtask

  // Delay bit, then nbits data bits MSB-first from a left-justified word
  task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits);
    bit_period(lr, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) bit_period(lr, word[31-i], (lr == 1'b1) && (i == 15));
  endtask

  task automatic frame16(input logic [15:0] l, input logic [15:0] r);
    exp_l_q.push_back(l);
    exp_r_q.push_back(r);
    send_slot(1'b0, {l, 16'h0000}, 31);
    send_slot(1'b1, {r, 16'h0000}, 31);
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic flush();
    repeat (12) @(negedge Clk);
    check("sb_drained", 32'(exp_l_q.size()), 32'd0);
  endtask

  int sv0, fe0;
  logic [15:0] rl, rr;

  initial begin
    aud.AUD_BCLK    = 1'b0;
    aud.AUD_ADCLRCK = 1'b1;
    aud.AUD_ADCDAT  = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_left", 32'(left_s), 32'h0);
    check("rst_right", 32'(right_s), 32'h0);
    check("rst_valid", 32'(sv_s), 32'h0);
    check("rst_ferr", 32'(fe_s), 32'h0);
    Reset = 1'b0;

    // 1: basic frame
    sv0 = sv_cnt; fe0 = fe_cnt;
    frame16(16'h4af3, 16'h0005);
    flush();
    check("t1_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
    check("t1_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("t1_left", 32'(left_s), 32'h4af3);
    check("t1_right", 32'(right_s), 32'h0005);

    // 2: reset, start mid right slot, then a full frame
    pulse_reset();
    check("t2_rst_left", 32'(left_s), 32'h0);
    sv0 = sv_cnt;
    send_slot(1'b1, 32'hdead_beef, 10);
    check("t2_partial_no_valid", 32'(sv_cnt - sv0), 32'd0);
    frame16(16'hfa8d, 16'h8000);
    flush();
    check("t2_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
    check("t2_left", 32'(left_s), 32'hfa8d);
    check("t2_right", 32'(right_s), 32'h8000);

    // 3: 24-bit slot data truncated to the 16 MSBs
    exp_l_q.push_back(16'h4af3);
    exp_r_q.push_back(16'hfa8d);
    send_slot(1'b0, {24'h4af312, 8'h00}, 31);
    send_slot(1'b1, {24'hfa8d7f, 8'h00}, 31);
    flush();
    check("t3_left", 32'(left_s), 32'h4af3);
    check("t3_right", 32'(right_s), 32'hfa8d);

    // 4: left slot cut after 10 bits
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_slot(1'b0, 32'h1111_0000, 10);
    send_slot(1'b1, 32'h2222_0000, 31);
    check("t4_ferr_cnt", 32'(fe_cnt - fe0), 32'd1);
    check("t4_no_valid", 32'(sv_cnt - sv0), 32'd0);
    check("t4_left_hold", 32'(left_s), 32'h4af3);
    check("t4_right_hold", 32'(right_s), 32'hfa8d);
    frame16(16'h1234, 16'habcd);
    flush();
    check("t4_left", 32'(left_s), 32'h1234);
    check("t4_right", 32'(right_s), 32'habcd);

    // 5: reset mid left slot
    sv0 = sv_cnt;
    send_slot(1'b0, 32'h5555_0000, 8);
    pulse_reset();
    check("t5_rst_left", 32'(left_s), 32'h0);
    check("t5_rst_right", 32'(right_s), 32'h0);
    for (int i = 8; i < 31; i++) bit_period(1'b0, 1'b1, 1'b0);
    send_slot(1'b1, 32'h6666_0000, 31);
    check("t5_no_valid", 32'(sv_cnt - sv0), 32'd0);
    frame16(16'h7e01, 16'h80ff);
    flush();
    check("t5_valid_cnt", 32'(sv_cnt - sv0), 32'd1);

    // 6: latency, then random frames
    frame16(16'h0f0f, 16'hf0f1);
    flush();
    check("t6_latency", 32'(valid_cyc - lsb_cyc), 32'(SS + 2));
    sv0 = sv_cnt;
    for (int n = 0; n < 100; n++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      frame16(rl, rr);
    end
    flush();
    check("t6_valid_cnt", 32'(sv_cnt - sv0), 32'd100);
    check("t6_left_last", 32'(left_s), 32'(rl));
    check("t6_right_last", 32'(right_s), 32'(rr));
    check("t6_latency_last", 32'(valid_cyc - lsb_cyc), 32'(SS + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
